// File: rtl/timer_pkg.sv
// Shared types and width helpers for the BCD stopwatch and its digit cells.
// Widths are derived from clock/fraction parameters at elaboration time.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Bit width needed to index v values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int period_of(input int clk_hz, input int sub_div);
    return clk_hz / sub_div;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the display counter: load, increment or decrement with wrap.
// carry_out flags the digit at its wrap point so the next digit can be enabled.
module bcd_digit
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] d,
  output logic       carry_out
);

  assign carry_out = up ? (d == BCD_NINE) : (d == BCD_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= BCD_ZERO;
    end else if (load) begin
      d <= load_val;
    end else if (en) begin
      if (carry_out) begin
        d <= up ? BCD_ZERO : BCD_NINE;
      end else begin
        d <= up ? d + 4'd1 : d - 4'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && load) begin
      assert (load_val <= BCD_NINE);
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Up/down seconds timer with sub-second fraction, BCD display value, lap capture and expiry.
// Outputs are registered; counting starts the cycle after run is seen in IDLE or PAUSED.
module bcd_stopwatch
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int SUB_DIV = 8,
  parameter int DIGITS  = 4,
  parameter int SEC_W   = 10,
  localparam int FRAC_W = clog2_min1(SUB_DIV),
  localparam int MSD_W  = clog2_min1(DIGITS),
  localparam int BCD_W  = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic              down,
  input  logic [BCD_W-1:0]  load_bcd,
  input  logic              lap,
  output logic [SEC_W-1:0]  sec,
  output logic [FRAC_W-1:0] frac,
  output logic [BCD_W-1:0]  bcd,
  output logic [MSD_W-1:0]  msd,
  output logic              tick,
  output logic [BCD_W-1:0]  lap_bcd,
  output logic              lap_valid,
  output logic              expired,
  output logic              ovf
);

  localparam int PERIOD = period_of(CLK_HZ, SUB_DIV);
  localparam int SUB_W  = clog2_min1(PERIOD);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PERIOD - 1);
  localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(SUB_DIV - 1);

  state_t             state;
  logic               mode_down;
  logic [SUB_W-1:0]   sub_cnt;
  logic               counting;
  logic               sub_wrap;
  logic               sec_step;
  logic               load_zero;
  logic               hits_zero;
  logic               bcd_wrap;
  logic               chain;
  logic [DIGITS-1:0]  dig_en;
  logic [DIGITS-1:0]  dig_co;
  logic [BCD_W-1:0]   load_val;

  assign counting  = (state == RUN) && run && !clear;
  assign sub_wrap  = counting && (sub_cnt == SUB_LAST);
  assign sec_step  = sub_wrap && (frac == FRAC_LAST);
  assign load_zero = (load_bcd == '0);
  assign load_val  = down ? load_bcd : '0;
  // Down count only ever reaches zero from a displayed value of one.
  assign hits_zero = mode_down && (bcd == BCD_W'(1));

  always_comb begin
    chain = sec_step;
    for (int k = 0; k < DIGITS; k++) begin
      dig_en[k] = chain;
      chain     = chain & dig_co[k];
    end
    bcd_wrap = chain & !mode_down;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst       (rst),
      .load      (clear),
      .load_val  (load_val[4*k +: 4]),
      .en        (dig_en[k]),
      .up        (!mode_down),
      .d         (bcd[4*k +: 4]),
      .carry_out (dig_co[k])
    );
  end

  always_comb begin
    msd = '0;
    for (int k = 1; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] != BCD_ZERO) msd = MSD_W'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_down <= 1'b0;
      sub_cnt   <= '0;
      frac      <= '0;
      sec       <= '0;
      tick      <= 1'b0;
      expired   <= 1'b0;
      ovf       <= 1'b0;
      lap_bcd   <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap && !clear;
      if (lap && !clear) lap_bcd <= bcd;

      if (clear) begin
        mode_down <= down;
        sub_cnt   <= '0;
        frac      <= '0;
        sec       <= '0;
        tick      <= 1'b0;
        ovf       <= 1'b0;
        expired   <= down && load_zero;
        state     <= (down && load_zero) ? DONE : IDLE;
      end else begin
        tick <= sec_step;
        if (counting) sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
        if (sub_wrap) frac <= frac + 1'b1;
        if (sec_step) begin
          sec <= sec + 1'b1;
          if ((&sec) || bcd_wrap) ovf <= 1'b1;
        end

        case (state)
          IDLE:   if (run) state <= RUN;
          RUN: begin
            if (!run) begin
              state <= PAUSED;
            end else if (sec_step && hits_zero) begin
              state   <= DONE;
              expired <= 1'b1;
            end
          end
          PAUSED: if (run) state <= RUN;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Parametrised up/down seconds timer with sub-second fraction, N-digit BCD display value, pause/resume, lap capture and countdown expiry.
- Sits between game/control FSMs and the 7-segment display driver.
- Replaces fixed 100 MHz / 4-digit / 1/8-s count-up timing in new designs.

Parameters:
- CLK_HZ, 100000000, input clock frequency; must be divisible by SUB_DIV.
- SUB_DIV, 8, fraction steps per second; power of two, 2..256.
- DIGITS, 4, BCD digits, 1..8.
- SEC_W, 10, binary elapsed-seconds width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clear  in  1  synchronous clear/load; stops the timer
- run  in  1  level; count while high
- down  in  1  mode, sampled only on clear: 0 = count up, 1 = count down
- load_bcd  in  4*DIGITS  countdown preload, sampled on clear with down=1
- lap  in  1  pulse; capture current bcd
- sec  out  SEC_W  elapsed whole seconds, binary, both modes
- frac  out  clog2(SUB_DIV)  elapsed fraction of current second
- bcd  out  4*DIGITS  display value: elapsed (up) or remaining (down); digit 0 is LSD
- msd  out  clog2(DIGITS), min 1  index of highest non-zero digit; 0 if all zero
- tick  out  1  one-cycle pulse on each whole-second step
- lap_bcd  out  4*DIGITS  last captured value
- lap_valid  out  1  one-cycle pulse, cycle after lap
- expired  out  1  sticky; countdown reached zero
- ovf  out  1  sticky; up-count wrapped past all nines or sec wrapped

Behaviour:
- Reset (async, rst=1):
  - all outputs 0
  - internal sub-counter 0
  - stored mode up
  - state IDLE
- Timebase:
  - PERIOD = CLK_HZ/SUB_DIV.
  - sub_cnt counts 0..PERIOD-1. At PERIOD-1 it returns to 0 and frac increments.
  - When frac = SUB_DIV-1 and sub_cnt = PERIOD-1, frac returns to 0 and tick fires on the same edge that updates sec/bcd.
  - tick is registered: it is high during the cycle in which the new sec/bcd are visible.
- States:
  - IDLE → RUN: run=1.
  - RUN → PAUSED: run=0. sub_cnt, frac and bcd are held; resume continues the partial second.
  - PAUSED → RUN: run=1.
  - RUN → DONE: down mode, and a tick makes bcd all zero. expired is set on that same edge.
  - DONE: counters frozen; bcd stays at 0 and expired stays 1 until clear.
  - Any state → IDLE on clear.
- clear:
  - Has priority over run and lap in the same cycle.
  - Zeroes sec, frac, sub_cnt, expired, ovf and tick. Latches down.
  - bcd becomes load_bcd if down=1, else 0.
  - clear with down=1 and load_bcd=0 goes directly to DONE with expired=1.
- Counting latency: run rising in IDLE → sub_cnt starts incrementing the next cycle. The first tick comes CLK_HZ cycles after the first counting cycle.
- BCD up count:
  - Ripple carry: digit k increments when all lower digits are 9.
  - All nines + tick → all zeros; ovf set.
- BCD down count:
  - Ripple borrow: digit k decrements when all lower digits are 0; a digit at 0 becomes 9.
  - bcd is never decremented below zero (DONE is entered first).
- sec:
  - Increments on every tick in both modes.
  - Wraps at 2^SEC_W; ovf is set on the wrap.
- lap:
  - Accepted in any state except while clear=1.
  - lap_bcd captures bcd as it is at the lap cycle, i.e. the pre-tick value if a tick edge coincides.
  - lap_valid is high the following cycle.
  - lap held high captures every cycle.
- msd: combinational from bcd; highest index whose digit is non-zero.
- Invalid digits (>9) in load_bcd: behaviour unspecified; checked by assertion only.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, PAUSED, DONE}
  - localparam helpers for PERIOD and width functions (clog2 with min 1)
  - BCD_NINE / BCD_ZERO constants
- Sub-module bcd_digit, instantiated DIGITS times via generate:
  - 4-bit register with en, up/down, load, load value
  - carry_out = (up & d==9) | (!up & d==0)
  - chained carry/borrow.
- Top level holds the timebase, FSM, sec, lap and sticky flags.

Test Plan (CLK_HZ=16, SUB_DIV=4, DIGITS=2, SEC_W=4 unless noted):
- Up count: clear(down=0), run=1 for 16*12 cycles →
  - 12 ticks; bcd=8'h12, sec=12, msd=1
  - frac steps every 4 cycles: 0,1,2,3.
- Pause: run low at cycle 16*3+6 for 20 cycles, then high →
  - bcd/frac/sub_cnt frozen during the pause
  - next tick occurs 10 counting cycles after resume; bcd=8'h04.
- Countdown: clear(down=1, load_bcd=8'h03), run=1 →
  - bcd 03→02→01→00 at 16-cycle ticks; expired=1 with the third tick
  - held in DONE for 100 cycles; sec=3.
- Wrap: up count for 100 ticks →
  - bcd 99→00, ovf=1 at tick 100; sec wraps at tick 16, also setting ovf.
- Lap/collisions:
  - lap on a tick edge at bcd=8'h07 → lap_bcd=8'h07, lap_valid next cycle.
  - clear+lap in the same cycle → no lap_valid.
  - clear(down=1, load=0) → expired=1 immediately.
- Reset mid-run: assert rst asynchronously between edges at bcd=8'h05 → all outputs 0 immediately; IDLE after release, no counting until run.
